// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter: captures a WIDTH-bit word on start/ready and
// streams it one bit per clock with bit_valid, bit_idx and a last-bit done pulse.

module piso_dff_cell (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic shift,
  input  logic load_d,
  input  logic shift_d,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        q <= 1'b0;
    else if (load)  q <= load_d;
    else if (shift) q <= shift_d;
  end

endmodule

module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [WIDTH-1:0]         din,
  output logic                     ready,
  output logic                     busy,
  output logic                     serial_out,
  output logic                     bit_valid,
  output logic [$clog2(WIDTH)-1:0] bit_idx,
  output logic                     done
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sr, load_vec, shift_vec;
  logic             load, shift, first_bit, head, last;
  logic             ready_n, valid_n, serial_n, done_n;
  logic [IW-1:0]    idx_n;

  // The first bit leaves on the accepting edge, so the chain is loaded with
  // din already advanced by one position; it drains to all-zero by the last bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    if (MSB_FIRST) begin : g_msb
      if (i == 0) begin : g_end
        assign load_vec[i]  = 1'b0;
        assign shift_vec[i] = 1'b0;
      end else begin : g_mid
        assign load_vec[i]  = din[i-1];
        assign shift_vec[i] = sr[i-1];
      end
    end else begin : g_lsb
      if (i == WIDTH - 1) begin : g_end
        assign load_vec[i]  = 1'b0;
        assign shift_vec[i] = 1'b0;
      end else begin : g_mid
        assign load_vec[i]  = din[i+1];
        assign shift_vec[i] = sr[i+1];
      end
    end

    piso_dff_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .shift   (shift),
      .load_d  (load_vec[i]),
      .shift_d (shift_vec[i]),
      .q       (sr[i])
    );
  end

  assign first_bit = MSB_FIRST ? din[WIDTH-1] : din[0];
  assign head      = MSB_FIRST ? sr[WIDTH-1]  : sr[0];
  assign last      = (bit_idx == LAST);
  assign busy      = ~ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ready      <= 1'b1;
      serial_out <= 1'b0;
      bit_valid  <= 1'b0;
      bit_idx    <= '0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      ready      <= ready_n;
      serial_out <= serial_n;
      bit_valid  <= valid_n;
      bit_idx    <= idx_n;
      done       <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = SHIFT;
      SHIFT:   if (last)  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next-cycle output values; start is not consulted while shifting.
  always_comb begin
    load     = 1'b0;
    shift    = 1'b0;
    ready_n  = 1'b1;
    valid_n  = 1'b0;
    serial_n = 1'b0;
    idx_n    = '0;
    done_n   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          ready_n  = 1'b0;
          valid_n  = 1'b1;
          serial_n = first_bit;
        end
      end
      SHIFT: begin
        if (!last) begin
          shift    = 1'b1;
          ready_n  = 1'b0;
          valid_n  = 1'b1;
          serial_n = head;
          idx_n    = bit_idx + 1'b1;
          done_n   = (idx_n == LAST);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share stimulus
// and are checked every cycle against a word/position model.

module tb_piso_serializer;

  logic       clk, rst, start;
  logic [7:0] din;
  logic [1:0] rdy, bsy, so, bv, dn;
  logic [2:0] idx [2];

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .start(start), .din(din),
    .ready(rdy[0]), .busy(bsy[0]), .serial_out(so[0]),
    .bit_valid(bv[0]), .bit_idx(idx[0]), .done(dn[0])
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .start(start), .din(din),
    .ready(rdy[1]), .busy(bsy[1]), .serial_out(so[1]),
    .bit_valid(bv[1]), .bit_idx(idx[1]), .done(dn[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: pos = transmit position of the current bit, -1 when idle.
  int         pos  = -1;
  logic [7:0] word = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pos  = -1;
      word = '0;
    end else if (pos < 0) begin
      if (start === 1'b1) begin
        word = din;
        pos  = 0;
      end
    end else begin
      pos = (pos == 7) ? -1 : pos + 1;
    end
  end

  int          n_cmp = 0, n_bad = 0;
  bit          cmp_en = 1'b0;
  int          nval [2];
  int          ndone [2];
  logic [15:0] col [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic clr();
    for (int m = 0; m < 2; m++) begin
      nval[m]  = 0;
      ndone[m] = 0;
      col[m]   = '0;
    end
  endtask

  task automatic tick();
    logic e_ser;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      if (cmp_en) begin
        e_ser = 1'b0;
        if (pos >= 0) e_ser = (m == 0) ? word[7-pos] : word[pos];
        chk($sformatf("m%0d.ready", m), rdy[m], pos < 0);
        chk($sformatf("m%0d.busy", m), bsy[m], pos >= 0);
        chk($sformatf("m%0d.bit_valid", m), bv[m], pos >= 0);
        chk($sformatf("m%0d.bit_idx", m), idx[m], (pos < 0) ? 0 : pos);
        chk($sformatf("m%0d.done", m), dn[m], pos == 7);
        chk($sformatf("m%0d.serial", m), so[m], e_ser);
      end
      if (bv[m] === 1'b1) begin
        nval[m]++;
        col[m] = {col[m][14:0], so[m]};
      end
      if (dn[m] === 1'b1) ndone[m]++;
    end
  endtask

  task automatic chk_idle_now(input string tag);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s.m%0d.ready", tag, m), rdy[m], 1);
      chk($sformatf("%s.m%0d.busy", tag, m), bsy[m], 0);
      chk($sformatf("%s.m%0d.bit_valid", tag, m), bv[m], 0);
      chk($sformatf("%s.m%0d.done", tag, m), dn[m], 0);
      chk($sformatf("%s.m%0d.bit_idx", tag, m), idx[m], 0);
      chk($sformatf("%s.m%0d.serial", tag, m), so[m], 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; din = '0;
    clr();
    // Asynchronous reset between clock edges
    #1 rst = 1'b1;
    #1 chk_idle_now("reset");
    @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;

    // Single word 0x1E: MSB-first 00011110, LSB-first 01111000
    clr();
    start = 1'b1; din = 8'h1E;
    tick();
    start = 1'b0; din = 8'h00;
    repeat (11) tick();
    chk("w1e.msb_stream", col[0][7:0], 8'h1E);
    chk("w1e.lsb_stream", col[1][7:0], 8'h78);
    chk("w1e.msb_nvalid", nval[0], 8);
    chk("w1e.lsb_nvalid", nval[1], 8);
    chk("w1e.msb_ndone", ndone[0], 1);

    // start with new data at bit_idx=3 is ignored
    clr();
    start = 1'b1; din = 8'h1E;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("busy.idx_at_pulse", idx[0], 3);
    start = 1'b1; din = 8'hFF;
    tick();
    start = 1'b0; din = 8'h00;
    repeat (8) tick();
    chk("busy.msb_stream", col[0][7:0], 8'h1E);
    chk("busy.lsb_stream", col[1][7:0], 8'h78);
    chk("busy.msb_nvalid", nval[0], 8);
    chk("busy.lsb_ndone", ndone[1], 1);

    // start held high: words every 9 cycles with a single idle gap
    clr();
    start = 1'b1; din = 8'hA5;
    tick();
    din = 8'h3C;
    repeat (7) tick();
    tick();
    chk("cont.gap_valid", bv[0], 0);
    chk("cont.gap_ready", rdy[0], 1);
    tick();
    chk("cont.restart_valid", bv[0], 1);
    start = 1'b0;
    repeat (10) tick();
    chk("cont.msb_stream", col[0], 16'hA53C);
    chk("cont.lsb_stream", col[1], 16'hA53C);
    chk("cont.msb_nvalid", nval[0], 16);
    chk("cont.msb_ndone", ndone[0], 2);
    chk("cont.lsb_ndone", ndone[1], 2);

    // Reset mid-word at bit_idx=4, then a clean word
    clr();
    start = 1'b1; din = 8'hA5;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("abort.idx_before", idx[0], 4);
    #2 rst = 1'b1;
    #1 chk_idle_now("abort");
    tick();
    rst = 1'b0;
    clr();
    start = 1'b1; din = 8'h81;
    tick();
    start = 1'b0; din = 8'h00;
    repeat (10) tick();
    chk("after.msb_stream", col[0][7:0], 8'h81);
    chk("after.lsb_stream", col[1][7:0], 8'h81);
    chk("after.msb_nvalid", nval[0], 8);
    chk("after.msb_ndone", ndone[0], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
